spi_flash_reader: RTL
=====================

# spi_flash_reader

Read-only SPI flash bridge that services 6809 CPU reads in the flash window (0x3000–0x3FFF) selected by the address decoder's `spi_ce`. On each new read it issues a serial READ command to the external flash, shifts in one byte, and stretches the CPU cycle via MRDY until the byte is valid. It sits directly downstream of the address decoder and drives the flash pins whenever the FT2232 is not in control of them.

## Interface
- `CLK_DIV`, 2: half-period of SCK in `i_clk` cycles (SCK = f_clk / (2·CLK_DIV)); legal range 1–255.
- `FLASH_BASE`, 24'h000000: byte offset added to the 12-bit window offset to form the flash address.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_spi_ce`  in  1  flash window select from the address decoder (already gated by FT2232 CS).
- `i_rw`  in  1  6809 R/W (1 = read).
- `i_addr`  in  12  CPU address bits [11:0] (offset within window).
- `o_data`  out  8  last byte read from flash.
- `o_mrdy`  out  1  1 = CPU may complete cycle; 0 = stretch.
- `o_spi_cs_n`  out  1  flash chip select, active low.
- `o_spi_sck`  out  1  serial clock, mode 0 (idle low).
- `o_spi_mosi`  out  1  serial data to flash.
- `i_spi_miso`  in  1  serial data from flash.
- `o_spi_oe`  out  1  1 = this block drives CS/SCK/MOSI; 0 = pins released to FT2232.

## Operation
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → [DUMMY] → DATA (8 bits) → DONE → IDLE.
- IDLE: request = `i_spi_ce & i_rw` sampled high while previous-cycle request was low (rising edge). On request: latch `FLASH_BASE + {12'b0, i_addr}` (24-bit, wraps modulo 2^24), drive CS low, go CMD.
- CMD shifts opcode 0x03 MSB first; ADDR shifts latched address MSB first; DATA samples MISO into shift register MSB first.
- Mode 0: MOSI updated while SCK low; MISO sampled on SCK rising edge; SCK returns low after last bit.
- DONE: `o_data` loaded from shift register on DATA→DONE transition; CS high; stay until `i_spi_ce` low, then IDLE.
- `o_mrdy` combinational: 0 when `i_spi_ce & i_rw` and state ≠ DONE; 1 otherwise (writes never stall, never touch flash).
- `o_spi_oe` = 1 from request acceptance until CS returns high; 0 in IDLE and DONE.
- Abort: `i_spi_ce` falls before DONE → CS high, SCK low next cycle, IDLE, `o_data` unchanged.
- Reset (any time, including mid-transfer): state IDLE, `o_spi_cs_n`=1, `o_spi_sck`=0, `o_spi_mosi`=0, `o_spi_oe`=0, `o_data`=8'h00, `o_mrdy`=1.

## Timing
- Request sampled at edge T0; CS low and state CMD visible after T0.
- Each bit = 2·CLK_DIV cycles (CLK_DIV low, CLK_DIV high).
- DONE entered at T0 + 1 + 80·CLK_DIV; `o_mrdy` high and `o_data` valid in that cycle (CLK_DIV=2 → 161 cycles).
- Back-to-back reads require `i_spi_ce` low ≥1 cycle between them; a continuously-high `i_spi_ce` never retriggers.
- CS high time between transfers ≥ 2 cycles.

## Configuration
- `SPI_FLASH_FAST_READ_EN` defined: opcode 0x0B, DUMMY state inserts 8 SCK cycles (MOSI=0) between ADDR and DATA; DONE at T0 + 1 + 96·CLK_DIV.
- Undefined: opcode 0x03, DUMMY state absent; timing as above.

## Structure
- Package `spi_flash_pkg`: state enum, opcode constants (READ 0x03, FAST_READ 0x0B), bit-count constants per phase.
- Sub-module `spi_shift_engine`: SCK divider, bit counter, MOSI/MISO shift registers, `done` pulse per phase; top holds FSM, address latch, MRDY/OE logic.

## Test plan
- Read, CLK_DIV=2, `i_addr`=12'h123, flash model returns 0xA5 → MOSI stream 0x03,0x000123; `o_mrdy` low 161 cycles; `o_data`=0xA5.
- Write cycle (`i_rw`=0, `i_spi_ce`=1) → `o_mrdy` stays 1, CS stays high, `o_data` unchanged.
- FLASH_BASE=24'hFFFFFF, `i_addr`=12'h002 → address shifted = 24'h000001 (wrap).
- `i_spi_ce` dropped after 40 cycles → CS high next cycle, IDLE, `o_data` keeps previous 0xA5; next read completes normally.
- `i_reset` low mid-ADDR → outputs at reset values immediately; after release, new read returns correct byte.
- With `SPI_FLASH_FAST_READ_EN`, CLK_DIV=1 → opcode 0x0B, 8 dummy clocks, `o_mrdy` high at T0+97, data correct.

Source files
------------

// File: rtl/spi_flash_reader_pkg.sv
// Shared types and constants for the SPI flash read bridge: FSM states,
// flash opcodes and the bit length of each serial phase.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam logic [5:0] CMD_BITS   = 6'd8;
  localparam logic [5:0] ADDR_BITS  = 6'd24;
  localparam logic [5:0] DUMMY_BITS = 6'd8;
  localparam logic [5:0] DATA_BITS  = 6'd8;

  // States in which the flash is selected and the pins are owned by the bridge
  function automatic logic is_active(state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// CPU-side bus of the SPI flash bridge: window select, R/W, offset address,
// returned byte and the MRDY cycle-stretch handshake.
interface spi_flash_reader_if;
  logic        i_spi_ce;
  logic        i_rw;
  logic [11:0] i_addr;
  logic [7:0]  o_data;
  logic        o_mrdy;

  modport master (output i_spi_ce, i_rw, i_addr, input o_data, o_mrdy);
  modport slave  (input i_spi_ce, i_rw, i_addr, output o_data, o_mrdy);
endinterface

// File: rtl/spi_flash_reader_shift_engine.sv
// Mode-0 SPI bit engine: SCK divider, per-phase bit counter, MOSI/MISO shift
// registers. A phase is loaded MSB-aligned in load_data; phase_done flags its last tick.
module spi_shift_engine #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        abort,
  input  logic [23:0] load_data,
  input  logic [5:0]  load_bits,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        busy,
  output logic        phase_done,
  output logic [7:0]  rx_byte
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [23:0] shift_q;
  logic [5:0]  bits_q;
  logic [7:0]  div_q;
  logic        sck_q;
  logic        busy_q;
  logic [7:0]  rx_q;
  logic        tick;

  assign tick = busy_q && (div_q == DIV_LAST);

  // A load landing on the falling edge of the previous phase keeps SCK seamless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bits_q  <= '0;
      div_q   <= '0;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      rx_q    <= '0;
    end else if (abort) begin
      div_q  <= '0;
      sck_q  <= 1'b0;
      busy_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      bits_q  <= load_bits;
      div_q   <= '0;
      sck_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (tick) begin
        div_q <= '0;
        if (!sck_q) begin
          sck_q <= 1'b1;
          rx_q  <= {rx_q[6:0], miso};
        end else begin
          sck_q   <= 1'b0;
          shift_q <= {shift_q[22:0], 1'b0};
          bits_q  <= bits_q - 6'd1;
          if (bits_q == 6'd1) busy_q <= 1'b0;
        end
      end else begin
        div_q <= div_q + 8'd1;
      end
    end
  end

  assign phase_done = tick && sck_q && (bits_q == 6'd1);
  assign sck        = sck_q;
  assign mosi       = busy_q & shift_q[23];
  assign busy       = busy_q;
  assign rx_byte    = rx_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Read-only SPI flash bridge for the 6809 flash window. Define SPI_FLASH_FAST_READ_EN
// to use FAST_READ (0x0B) with eight dummy clocks instead of plain READ (0x03).
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned  CLK_DIV    = 2,
  parameter logic [23:0]  FLASH_BASE = 24'h000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  spi_flash_reader_if.slave  bus,
  output logic               o_spi_cs_n,
  output logic               o_spi_sck,
  output logic               o_spi_mosi,
  input  logic               i_spi_miso,
  output logic               o_spi_oe
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = OP_FAST_READ;
`else
  localparam logic [7:0] OPCODE = OP_READ;
`endif

  state_t      state_q, state_d;
  logic [23:0] addr_q;
  logic [7:0]  data_q;
  logic        armed_q;
  logic        cs_n_q;
  logic        cs_guard_q;
  logic        req;
  logic        load, abort, eng_busy, phase_done;
  logic [23:0] load_data;
  logic [5:0]  load_bits;
  logic [7:0]  rx_byte;

  assign req = bus.i_spi_ce & bus.i_rw;

  // armed_q re-arms only once the request drops, so a held select never retriggers;
  // cs_guard_q holds off a new transfer for one cycle after CS rises
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      armed_q    <= 1'b1;
      cs_n_q     <= 1'b1;
      cs_guard_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= !is_active(state_d);
      cs_guard_q <= !cs_n_q;
      if (state_q == ST_IDLE && state_d == ST_CMD) begin
        addr_q  <= FLASH_BASE + {12'h000, bus.i_addr};
        armed_q <= 1'b0;
      end else if (!req) begin
        armed_q <= 1'b1;
      end
      if (state_q == ST_DATA && state_d == ST_DONE) data_q <= rx_byte;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_data = '0;
    load_bits = CMD_BITS;
    abort     = is_active(state_q) && !bus.i_spi_ce;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (req && armed_q && !cs_guard_q) state_d = ST_CMD;
        ST_CMD: begin
          if (!eng_busy) begin
            load      = 1'b1;
            load_data = {OPCODE, 16'h0000};
            load_bits = CMD_BITS;
          end else if (phase_done) begin
            state_d   = ST_ADDR;
            load      = 1'b1;
            load_data = addr_q;
            load_bits = ADDR_BITS;
          end
        end
        ST_ADDR: if (phase_done) begin
          load = 1'b1;
`ifdef SPI_FLASH_FAST_READ_EN
          state_d   = ST_DUMMY;
          load_bits = DUMMY_BITS;
`else
          state_d   = ST_DATA;
          load_bits = DATA_BITS;
`endif
        end
        ST_DUMMY: if (phase_done) begin
          state_d   = ST_DATA;
          load      = 1'b1;
          load_bits = DATA_BITS;
        end
        ST_DATA: if (phase_done) state_d = ST_DONE;
        ST_DONE: if (!bus.i_spi_ce) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .load       (load),
    .abort      (abort),
    .load_data  (load_data),
    .load_bits  (load_bits),
    .miso       (i_spi_miso),
    .sck        (o_spi_sck),
    .mosi       (o_spi_mosi),
    .busy       (eng_busy),
    .phase_done (phase_done),
    .rx_byte    (rx_byte)
  );

  assign o_spi_cs_n = cs_n_q;
  assign o_spi_oe   = !cs_n_q;
  assign bus.o_data = data_q;
  assign bus.o_mrdy = !i_reset || !(req && state_q != ST_DONE);

endmodule
